// File: rtl/lc4_pkg.sv
// Shared LC4 opcode and condition-code constants for the core pipeline stages.
package lc4_pkg;

    localparam logic [3:0] OP_BR      = 4'b0000;
    localparam logic [3:0] OP_ARITH   = 4'b0001;
    localparam logic [3:0] OP_CMP     = 4'b0010;
    localparam logic [3:0] OP_JSR     = 4'b0100;
    localparam logic [3:0] OP_LOGIC   = 4'b0101;
    localparam logic [3:0] OP_LDR     = 4'b0110;
    localparam logic [3:0] OP_STR     = 4'b0111;
    localparam logic [3:0] OP_RTI     = 4'b1000;
    localparam logic [3:0] OP_CONST   = 4'b1001;
    localparam logic [3:0] OP_SHIFT   = 4'b1010;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_HICONST = 4'b1101;
    localparam logic [3:0] OP_TRAP    = 4'b1111;

    localparam logic [2:0] NZP_N     = 3'b100;
    localparam logic [2:0] NZP_Z     = 3'b010;
    localparam logic [2:0] NZP_P     = 3'b001;
    localparam logic [2:0] NZP_RESET = NZP_Z;

endpackage

// File: rtl/lc4_nzp_gen.sv
// Combinational {N,Z,P} classification of a signed WORD_SIZE value.
module lc4_nzp_gen
    import lc4_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] i_value,
    output logic [2:0]           o_nzp
);

    always_comb begin
        if (i_value[WORD_SIZE-1]) begin
            o_nzp = NZP_N;
        end else if (i_value == '0) begin
            o_nzp = NZP_Z;
        end else begin
            o_nzp = NZP_P;
        end
    end

endmodule

// File: rtl/lc4_writeback_stage.sv
// LC4 writeback stage: register-file write, NZP update and control-flow redirect.
// Optional privilege bit (o_psr_priv) is built when LC4_PSR_EN is defined.
module lc4_writeback_stage
    import lc4_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_x_valid,
    output logic                 o_x_ready,
    input  logic [15:0]          i_x_insn,
    input  logic [15:0]          i_x_pc,
    input  logic [WORD_SIZE-1:0] i_x_result,
    input  logic [WORD_SIZE-1:0] i_x_dmem_rdata,
    input  logic                 i_stall,
    input  logic                 i_flush,
    output logic                 o_w_valid,
    output logic [15:0]          o_w_insn,
    output logic [15:0]          o_w_pc,
    output logic                 o_rf_we,
    output logic [2:0]           o_rf_wsel,
    output logic [WORD_SIZE-1:0] o_rf_wdata,
    output logic [2:0]           o_nzp,
    output logic                 o_redirect,
    output logic [15:0]          o_redirect_pc
`ifdef LC4_PSR_EN
    ,
    output logic                 o_psr_priv
`endif
);

    logic                 valid_q;
    logic [15:0]          insn_q;
    logic [15:0]          pc_q;
    logic                 we_q;
    logic [2:0]           wsel_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [2:0]           nzp_q;
    logic                 redirect_q;
    logic [15:0]          redirect_pc_q;

    logic [3:0]           opcode;
    logic [15:0]          pc_inc;
    logic                 cap;
    logic                 we;
    logic [2:0]           wsel;
    logic [WORD_SIZE-1:0] wdata;
    logic                 taken;
    logic                 is_cmp;
    logic                 rti_ok;
    logic [WORD_SIZE-1:0] nzp_src;
    logic [2:0]           nzp_new;

    assign opcode = i_x_insn[15:12];
    assign pc_inc = i_x_pc + 16'd1;
    // A registered redirect squashes the wrong-path instruction now in X.
    assign cap    = i_x_valid & ~i_stall & ~i_flush & ~redirect_q;

`ifdef LC4_PSR_EN
    logic priv_q;

    // RTI from user mode is demoted to a NOP.
    assign rti_ok = priv_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            priv_q <= 1'b1;
        end else if (cap) begin
            if (opcode == OP_TRAP) begin
                priv_q <= 1'b1;
            end else if (opcode == OP_RTI) begin
                priv_q <= 1'b0;
            end
        end
    end

    assign o_psr_priv = priv_q;
`else
    assign rti_ok = 1'b1;
`endif

    always_comb begin
        we     = 1'b0;
        wsel   = i_x_insn[11:9];
        wdata  = i_x_result;
        taken  = 1'b0;
        is_cmp = 1'b0;
        case (opcode)
            OP_ARITH, OP_LOGIC, OP_CONST, OP_SHIFT, OP_HICONST: begin
                we = 1'b1;
            end
            OP_LDR: begin
                we    = 1'b1;
                wdata = i_x_dmem_rdata;
            end
            OP_JSR, OP_TRAP: begin
                we    = 1'b1;
                wsel  = 3'd7;
                wdata = WORD_SIZE'(pc_inc);
                taken = 1'b1;
            end
            OP_CMP: is_cmp = 1'b1;
            OP_BR:  taken  = |(i_x_insn[11:9] & nzp_q);
            OP_JMP: taken  = 1'b1;
            OP_RTI: taken  = rti_ok;
            default: ;
        endcase
    end

    assign nzp_src = is_cmp ? i_x_result : wdata;

    lc4_nzp_gen #(
        .WORD_SIZE (WORD_SIZE)
    ) u_nzp_gen (
        .i_value (nzp_src),
        .o_nzp   (nzp_new)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q       <= 1'b0;
            insn_q        <= '0;
            pc_q          <= '0;
            we_q          <= 1'b0;
            wsel_q        <= '0;
            wdata_q       <= '0;
            nzp_q         <= NZP_RESET;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (!i_stall) begin
            valid_q       <= cap;
            insn_q        <= i_x_insn;
            pc_q          <= i_x_pc;
            we_q          <= cap & we;
            wsel_q        <= wsel;
            wdata_q       <= wdata;
            redirect_q    <= cap & taken;
            redirect_pc_q <= i_x_result[15:0];
            if (cap & (we | is_cmp)) begin
                nzp_q <= nzp_new;
            end
        end
    end

    assign o_x_ready     = ~i_stall;
    assign o_w_valid     = valid_q;
    assign o_w_insn      = insn_q;
    assign o_w_pc        = pc_q;
    assign o_rf_we       = we_q;
    assign o_rf_wsel     = wsel_q;
    assign o_rf_wdata    = wdata_q;
    assign o_nzp         = nzp_q;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_lc4_writeback_stage.sv
// Self-checking bench for lc4_writeback_stage: directed scenarios plus randomized model check.
module tb_lc4_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_valid, x_ready;
    logic [15:0] x_insn, x_pc, x_result, x_dmem_rdata;
    logic        stall, flush;
    logic        w_valid;
    logic [15:0] w_insn, w_pc;
    logic        rf_we;
    logic [2:0]  rf_wsel;
    logic [15:0] rf_wdata;
    logic [2:0]  nzp;
    logic        redirect;
    logic [15:0] redirect_pc;
`ifdef LC4_PSR_EN
    logic        psr_priv;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid, m_we, m_redir;
    logic [2:0]  m_sel, m_nzp;
    logic [15:0] m_wdata, m_rpc, m_insn, m_pc;
    logic        m_priv;

    lc4_writeback_stage #(.WORD_SIZE(16)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_x_valid      (x_valid),
        .o_x_ready      (x_ready),
        .i_x_insn       (x_insn),
        .i_x_pc         (x_pc),
        .i_x_result     (x_result),
        .i_x_dmem_rdata (x_dmem_rdata),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_w_valid      (w_valid),
        .o_w_insn       (w_insn),
        .o_w_pc         (w_pc),
        .o_rf_we        (rf_we),
        .o_rf_wsel      (rf_wsel),
        .o_rf_wdata     (rf_wdata),
        .o_nzp          (nzp),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirect_pc)
`ifdef LC4_PSR_EN
        ,
        .o_psr_priv     (psr_priv)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] flags(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] insn, input logic [15:0] pc,
                         input logic [15:0] res, input logic [15:0] rd,
                         input logic st, input logic fl);
        x_valid = v; x_insn = insn; x_pc = pc; x_result = res; x_dmem_rdata = rd;
        stall = st; flush = fl;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 16'h1240, 16'h0040, 16'h8000, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h4A00, 16'h0050, 16'h0300, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (redirect !== 1'b1 || rf_we !== 1'b1)
            begin errors++; $display("FAIL reset_pre: redirect=%b we=%b want 1 1", redirect, rf_we); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({w_valid, w_insn, w_pc, rf_we, rf_wsel, rf_wdata, redirect, redirect_pc} !== '0)
            begin errors++; $display("FAIL reset_outputs: v=%b insn=%h pc=%h we=%b sel=%0d wd=%h rd=%b rpc=%h want all 0",
                w_valid, w_insn, w_pc, rf_we, rf_wsel, rf_wdata, redirect, redirect_pc); end
        checks++;
        if (nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b want 010", nzp); end
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        do_reset();
        drive(1'b1, 16'h1240, 16'h0100, 16'h8000, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (w_valid !== 1'b1 || rf_we !== 1'b1 || rf_wsel !== 3'd1 || rf_wdata !== 16'h8000)
            begin errors++; $display("FAIL add_write: v=%b we=%b sel=%0d wd=%h want 1 1 1 8000",
                w_valid, rf_we, rf_wsel, rf_wdata); end
        checks++;
        if (nzp !== 3'b100) begin errors++; $display("FAIL add_nzp: got %b want 100", nzp); end
        checks++;
        if (w_insn !== 16'h1240 || w_pc !== 16'h0100 || redirect !== 1'b0)
            begin errors++; $display("FAIL add_regs: insn=%h pc=%h rd=%b want 1240 0100 0",
                w_insn, w_pc, redirect); end
        // LDR takes the memory data, not the ALU result
        drive(1'b1, 16'h6A00, 16'h0101, 16'h1111, 16'h0000, 1'b0, 1'b0);
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_wsel !== 3'd5 || rf_wdata !== 16'h0000 || nzp !== 3'b010)
            begin errors++; $display("FAIL ldr: we=%b sel=%0d wd=%h nzp=%b want 1 5 0000 010",
                rf_we, rf_wsel, rf_wdata, nzp); end
    endtask

    task automatic test_brz();
        do_reset();
        drive(1'b1, 16'h1000, 16'h0100, 16'h0005, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h2200, 16'h0101, 16'h0000, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (nzp !== 3'b010 || rf_we !== 1'b0)
            begin errors++; $display("FAIL cmp: nzp=%b we=%b want 010 0", nzp, rf_we); end
        drive(1'b1, 16'h0405, 16'h0102, 16'h0031, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0031 || rf_we !== 1'b0)
            begin errors++; $display("FAIL brz_taken: rd=%b rpc=%h we=%b want 1 0031 0",
                redirect, redirect_pc, rf_we); end
        drive(1'b1, 16'h1240, 16'h0103, 16'hFFFF, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (w_valid !== 1'b0 || redirect !== 1'b0 || nzp !== 3'b010)
            begin errors++; $display("FAIL brz_squash: v=%b rd=%b nzp=%b want 0 0 010",
                w_valid, redirect, nzp); end
        drive(1'b1, 16'h0A05, 16'h0104, 16'h0031, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (redirect !== 1'b0 || w_valid !== 1'b1)
            begin errors++; $display("FAIL brnp_not_taken: rd=%b v=%b want 0 1", redirect, w_valid); end
        drive(1'b1, 16'h0000, 16'h0105, 16'h0031, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (redirect !== 1'b0)
            begin errors++; $display("FAIL nop_not_taken: rd=%b want 0", redirect); end
    endtask

    task automatic test_jsr();
        do_reset();
        drive(1'b1, 16'h4800, 16'h0010, 16'h0200, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (rf_we !== 1'b1 || rf_wsel !== 3'd7 || rf_wdata !== 16'h0011 || nzp !== 3'b001)
            begin errors++; $display("FAIL jsr_write: we=%b sel=%0d wd=%h nzp=%b want 1 7 0011 001",
                rf_we, rf_wsel, rf_wdata, nzp); end
        checks++;
        if (redirect !== 1'b1 || redirect_pc !== 16'h0200)
            begin errors++; $display("FAIL jsr_redirect: rd=%b rpc=%h want 1 0200", redirect, redirect_pc); end
        // TRAP at the top of memory wraps PC+1 to zero
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hF025, 16'hFFFF, 16'h8025, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (rf_wdata !== 16'h0000 || nzp !== 3'b010 || redirect_pc !== 16'h8025)
            begin errors++; $display("FAIL trap_wrap: wd=%h nzp=%b rpc=%h want 0000 010 8025",
                rf_wdata, nzp, redirect_pc); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1'b1, 16'h1240, 16'h0020, 16'hF000, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hC000, 16'h0021, 16'h0400, 16'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 16'h0030 + 16'(i), 16'h0001, 16'h0, 1'b1, 1'b0);
            #1;
            checks++;
            if (x_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", x_ready); end
            tick();
            checks++;
            if (w_insn !== 16'hC000 || w_pc !== 16'h0021 || w_valid !== 1'b1 || nzp !== 3'b100 ||
                redirect !== 1'b1 || redirect_pc !== 16'h0400)
                begin errors++; $display("FAIL stall_hold: insn=%h pc=%h v=%b nzp=%b rd=%b rpc=%h want C000 0021 1 100 1 0400",
                    w_insn, w_pc, w_valid, nzp, redirect, redirect_pc); end
        end
        drive(1'b1, 16'h1000, 16'h0022, 16'h0001, 16'h0, 1'b0, 1'b0);
        #1;
        checks++;
        if (x_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready: got %b want 1", x_ready); end
        tick();
        checks++;
        if (redirect !== 1'b0 || w_valid !== 1'b0 || nzp !== 3'b100)
            begin errors++; $display("FAIL stall_release: rd=%b v=%b nzp=%b want 0 0 100",
                redirect, w_valid, nzp); end
    endtask

    task automatic test_flush_redirect();
        do_reset();
        drive(1'b1, 16'h1240, 16'h0040, 16'h0007, 16'h0, 1'b0, 1'b1);
        tick();
        checks++;
        if (w_valid !== 1'b0 || rf_we !== 1'b0 || nzp !== 3'b010)
            begin errors++; $display("FAIL flush: v=%b we=%b nzp=%b want 0 0 010", w_valid, rf_we, nzp); end
        drive(1'b1, 16'hC1C0, 16'h0041, 16'h0600, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h1240, 16'h0042, 16'h0007, 16'h0, 1'b0, 1'b1);
        tick();
        checks++;
        if (w_valid !== 1'b0 || redirect !== 1'b0)
            begin errors++; $display("FAIL flush_redirect: v=%b rd=%b want 0 0", w_valid, redirect); end
    endtask

`ifdef LC4_PSR_EN
    task automatic test_psr();
        do_reset();
        checks++;
        if (psr_priv !== 1'b1) begin errors++; $display("FAIL psr_reset: got %b want 1", psr_priv); end
        drive(1'b1, 16'hF025, 16'h0060, 16'h8025, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (psr_priv !== 1'b1) begin errors++; $display("FAIL psr_trap: got %b want 1", psr_priv); end
        drive(1'b1, 16'h8000, 16'h8030, 16'h0061, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (psr_priv !== 1'b0 || redirect !== 1'b1)
            begin errors++; $display("FAIL psr_rti: priv=%b rd=%b want 0 1", psr_priv, redirect); end
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h8000, 16'h0062, 16'h0070, 16'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (redirect !== 1'b0 || rf_we !== 1'b0 || psr_priv !== 1'b0)
            begin errors++; $display("FAIL psr_rti_user: rd=%b we=%b priv=%b want 0 0 0",
                redirect, rf_we, psr_priv); end
    endtask
`endif

    task automatic test_random();
        logic        v, st, fl, cap_m, we_m, tk_m;
        logic [15:0] insn, pc, res, rd, wd_m;
        logic [2:0]  sel_m;
        logic [3:0]  op;
        do_reset();
        m_valid = 1'b0; m_we = 1'b0; m_redir = 1'b0; m_nzp = 3'b010; m_priv = 1'b1;
        for (int n = 0; n < 500; n++) begin
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 9) == 0);
            insn = 16'($urandom);
            pc   = 16'($urandom);
            res  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            rd   = 16'($urandom);
            drive(v, insn, pc, res, rd, st, fl);
            #1;
            checks++;
            if (x_ready !== !st)
                begin errors++; $display("FAIL rand_ready %0d: got %b want %b", n, x_ready, !st); end
            if (!st) begin
                op    = insn[15:12];
                cap_m = v && !fl && !m_redir;
                we_m  = op inside {4'h1, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hD, 4'hF};
                sel_m = (op == 4'h4 || op == 4'hF) ? 3'd7 : insn[11:9];
                wd_m  = (op == 4'h6) ? rd : (op == 4'h4 || op == 4'hF) ? pc + 16'd1 : res;
                tk_m  = (op == 4'h0) ? ((insn[11:9] & m_nzp) != 3'b000)
                                     : (op inside {4'h4, 4'h8, 4'hC, 4'hF});
`ifdef LC4_PSR_EN
                if (op == 4'h8 && !m_priv) tk_m = 1'b0;
                if (cap_m && op == 4'hF) m_priv = 1'b1;
                if (cap_m && op == 4'h8) m_priv = 1'b0;
`endif
                if (cap_m && we_m) m_nzp = flags(wd_m);
                else if (cap_m && op == 4'h2) m_nzp = flags(res);
                m_valid = cap_m; m_we = cap_m && we_m; m_sel = sel_m; m_wdata = wd_m;
                m_redir = cap_m && tk_m; m_rpc = res; m_insn = insn; m_pc = pc;
            end
            tick();
            checks++;
            if (w_valid !== m_valid || rf_we !== m_we || redirect !== m_redir || nzp !== m_nzp)
                begin errors++; $display("FAIL rand_ctrl %0d: v/we/rd/nzp=%b %b %b %b want %b %b %b %b",
                    n, w_valid, rf_we, redirect, nzp, m_valid, m_we, m_redir, m_nzp); end
            if (m_we) begin
                checks++;
                if (rf_wsel !== m_sel || rf_wdata !== m_wdata)
                    begin errors++; $display("FAIL rand_write %0d: sel=%0d wd=%h want %0d %h",
                        n, rf_wsel, rf_wdata, m_sel, m_wdata); end
            end
            if (m_valid) begin
                checks++;
                if (w_insn !== m_insn || w_pc !== m_pc)
                    begin errors++; $display("FAIL rand_insn %0d: insn=%h pc=%h want %h %h",
                        n, w_insn, w_pc, m_insn, m_pc); end
            end
            if (m_redir) begin
                checks++;
                if (redirect_pc !== m_rpc)
                    begin errors++; $display("FAIL rand_target %0d: got %h want %h", n, redirect_pc, m_rpc); end
            end
`ifdef LC4_PSR_EN
            checks++;
            if (psr_priv !== m_priv)
                begin errors++; $display("FAIL rand_priv %0d: got %b want %b", n, psr_priv, m_priv); end
`endif
        end
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        test_reset();
        test_add();
        test_brz();
        test_jsr();
        test_stall();
        test_flush_redirect();
`ifdef LC4_PSR_EN
        test_psr();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc4_writeback_stage.md
Name: lc4_writeback_stage

Overview:
- Registered stage directly downstream of lc4_alu: captures the executed instruction, its PC, the ALU result and data-memory read data.
- Selects the register-file write value, updates the NZP condition-code register and resolves control flow (branch taken / redirect target).
- Drives the register-file write port and the fetch-redirect interface of the LC4 core.

Parameters:
- WORD_SIZE, 16, datapath width of results and register data; PC and insn stay 16 bits.

Ports:
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_x_valid  in  1  execute stage presents a valid instruction
- o_x_ready  out  1  stage will capture this cycle; equals ~i_stall
- i_x_insn  in  16  instruction word
- i_x_pc  in  16  instruction PC
- i_x_result  in  WORD_SIZE  lc4_alu o_result for this instruction
- i_x_dmem_rdata  in  WORD_SIZE  data-memory read data (asynchronous read, valid with X)
- i_stall  in  1  hold the stage register
- i_flush  in  1  kill the instruction presented this cycle
- o_w_valid  out  1  registered instruction valid
- o_w_insn  out  16  registered instruction
- o_w_pc  out  16  registered PC
- o_rf_we  out  1  register-file write enable (gated by o_w_valid)
- o_rf_wsel  out  3  destination register
- o_rf_wdata  out  WORD_SIZE  register write data
- o_nzp  out  3  current NZP register {N,Z,P}
- o_redirect  out  1  one-cycle redirect request to fetch
- o_redirect_pc  out  16  redirect target

Behaviour:
- Reset (async, i_rst_n=0):
  - o_w_valid=0, o_w_insn=0, o_w_pc=0, o_rf_we=0, o_rf_wsel=0, o_rf_wdata=0, o_redirect=0, o_redirect_pc=0.
  - NZP=3'b010.
  - Reset mid-operation discards the held instruction.
- Capture condition: cap = i_x_valid & ~i_stall & ~i_flush & ~o_redirect.
  - On each rising edge with ~i_stall: o_w_valid<=cap; insn, pc and the computed wdata/wsel/we/redirect are registered.
  - Latency 1 cycle.
- i_stall=1: every register, including NZP and o_redirect, holds. Stall has priority over flush and redirect-squash.
- Wrong-path squash: while o_redirect=1 and ~i_stall, the instruction presented by X is dropped (o_w_valid<=0).
- Write data:
  - LDR (0110): i_x_dmem_rdata.
  - JSR/JSRR (0100) and TRAP (1111): i_x_pc+1, modulo 2^16, zero-extended to WORD_SIZE.
  - Otherwise: i_x_result.
- Register write:
  - we=1 for opcodes 0001, 0101, 0110, 1001, 1010, 1101 with wsel=insn[11:9].
  - we=1 for 0100 and 1111 with wsel=7.
  - we=0 for 0000, 0010, 0111, 1000, 1100.
- NZP update, at the capture edge:
  - Every captured instruction with we=1 sets NZP from the signed sign/zero of its write data.
  - CMP (0010) sets NZP from i_x_result (FFFF→100, 0000→010, 0001→001) and writes no register.
  - All others leave NZP unchanged.
  - The next instruction therefore sees the updated NZP with no bypass.
- Redirect, registered with the instruction:
  - BR (0000): taken = |(insn[11:9] & NZP). NZP here is the value before this capture edge, which already includes the previous instruction's update. NOP (insn[11:9]=0) is never taken.
  - JMP/JMPR (1100), JSR/JSRR (0100), TRAP (1111), RTI (1000): always taken.
  - Target = i_x_result in all cases.
  - o_redirect pulses for exactly one unstalled cycle.
- Simultaneous i_flush and o_redirect: the stage still captures nothing. A redirect already registered is still issued.

Optional Feature:
- Macro: LC4_PSR_EN.
- When defined, adds output o_psr_priv (1 bit).
  - Reset value 1.
  - Set when a TRAP is captured; cleared when an RTI is captured; holds on stall.
  - A captured RTI with o_psr_priv=0 gives no redirect and no write (treated as NOP).
- When undefined: no port, no register, RTI always redirects.

Decomposition:
- Shared package lc4_pkg:
  - 4-bit opcode constants (OP_BR, OP_ARITH, OP_CMP, OP_JSR, OP_LOGIC, OP_LDR, OP_STR, OP_RTI, OP_CONST, OP_SHIFT, OP_JMP, OP_HICONST, OP_TRAP).
  - NZP encodings and the NZP reset value.
- One combinational sub-module, lc4_nzp_gen: WORD_SIZE value → {N,Z,P}. It is reused by the decode-stage branch predictor.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream → all outputs 0, o_nzp=010 immediately, without waiting for a clock edge.
- ADD: insn 16'h1240 (R1=R1+R0), i_x_result=16'h8000 → next cycle o_rf_we=1, o_rf_wsel=1, o_rf_wdata=8000, o_nzp=100.
- BRz: CMP with result 0000, then BRz (16'h0405), i_x_result=16'h0031 → o_redirect=1, o_redirect_pc=0031; the following X instruction is dropped (o_w_valid=0).
- JSR at pc 16'h0010, i_x_result=16'h0200 → wsel=7, wdata=0011, o_nzp=001, redirect to 0200.
- Stall: hold i_stall=1 for 3 cycles while X changes → o_w_* and o_nzp unchanged, o_x_ready=0, no repeated redirect pulse.
- LC4_PSR_EN: TRAP x25 → o_psr_priv=1; RTI → 0; a second RTI → no redirect, o_rf_we=0.
